// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the two-thread FPU issue arbiter.
//   state_e      : arbiter state encoding (IDLE = 0, LONG = 1)
//   THR0 / THR1  : thread identifiers used for grants and the operand select
//   LONG_LAT_DEF : default occupancy of a long op (div/sqrt), issue cycle included
package fpu_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LONG = 1'b1
    } state_e;

    localparam logic THR0 = 1'b0;
    localparam logic THR1 = 1'b1;

    localparam int unsigned LONG_LAT_DEF = 4;

endpackage

// File: rtl/fpu_busy_cnt.sv
// Occupancy counter for a long FPU op.
//   clk   : clock, rising edge
//   clrn  : asynchronous active-low reset (count cleared to 0)
//   load  : a long op issues this cycle; count loads LONG_LAT-1
//   dec   : FPU occupied; count steps down by one
//   last  : final occupied cycle (count == 1)
module fpu_busy_cnt #(
    parameter int unsigned LONG_LAT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic clrn,
    input  logic load,
    input  logic dec,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(LONG_LAT - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/fpu_thread_arbiter.sv
// Issue arbiter for an FPU shared by two hardware threads.
// Grants are combinational from the requests. A long op (div/sqrt) holds the
// FPU for LONG_LAT cycles, during which nothing issues and every request stalls.
// Build option: define FPU_ARB_RR_EN for round-robin conflict resolution;
// otherwise thread 0 wins every conflict and no priority pointer exists.
//   clk, clrn    : clock (rising edge) and asynchronous active-low reset
//   req0, req1   : thread has an FP op ready to issue
//   long0, long1 : that thread's op is long (qualified by its req)
//   s            : FPU operand/destination select (0 = thread 0)
//   gnt0, gnt1   : op issues this cycle
//   stall0/1     : thread holds its op (req & ~gnt)
//   busy         : long op in flight
module fpu_thread_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned LONG_LAT = LONG_LAT_DEF,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic clrn,
    input  logic req0,
    input  logic req1,
    input  logic long0,
    input  logic long1,
    output logic s,
    output logic gnt0,
    output logic gnt1,
    output logic stall0,
    output logic stall1,
    output logic busy
);

    state_e state, state_nxt;
    logic   last_sel;
    logic   win;
    logic   idle;
    logic   gnt_any;
    logic   long_issue;
    logic   cnt_last;

`ifdef FPU_ARB_RR_EN
    logic   pri;
`endif

    always_comb begin
        // Grants are suppressed while reset is held, not just after it lands.
        idle = clrn && (state == IDLE);

        if (req0 && req1) begin
`ifdef FPU_ARB_RR_EN
            win = pri;
`else
            win = THR0;
`endif
        end else begin
            win = req1 ? THR1 : THR0;
        end

        gnt0    = idle && req0 && (win == THR0);
        gnt1    = idle && req1 && (win == THR1);
        gnt_any = gnt0 || gnt1;

        // Without a grant the FPU keeps its current operand source.
        s       = gnt_any ? win : last_sel;
        stall0  = req0 && !gnt0;
        stall1  = req1 && !gnt1;
        busy    = (state == LONG);

        long_issue = (gnt0 && long0) || (gnt1 && long1);

        state_nxt = state;
        unique case (state)
            IDLE:    if (long_issue) state_nxt = LONG;
            LONG:    if (cnt_last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            last_sel <= THR0;
        end else begin
            state <= state_nxt;
            if (gnt_any) begin
                last_sel <= win;
            end
        end
    end

`ifdef FPU_ARB_RR_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pri <= THR0;
        end else if (gnt_any) begin
            pri <= ~win;
        end
    end
`endif

    fpu_busy_cnt #(
        .LONG_LAT (LONG_LAT),
        .CNT_W    (CNT_W)
    ) u_busy_cnt (
        .clk  (clk),
        .clrn (clrn),
        .load (long_issue),
        .dec  (busy),
        .last (cnt_last)
    );

endmodule
